decode_pc_control: RTL and testbench
====================================

// Module: decode_pc_control
// PURPOSE
//   ID-stage control that consumes the fetch pipeline register (if_id_instruc, if_id_nextpc).
//   Drives every fetch redirect/stall input: id_stall, id_if_selpcsource/selpctype and the 3 targets.
//   Resolves branches, jumps and exceptions in ID; detects load-use and branch-operand hazards.
//   Registers decoded operands into the ID/EX pipeline register; squashes the slot after an exception.
// PARAMETERS
//   EXC_VECTOR  32'h0000_0040  exception target; must equal fetch's hard-wired selpctype 2'b11 target
// PORTS
//   clock             in   1   rising-edge clock (single clock domain)
//   reset             in   1   asynchronous, active-low reset
//   if_id_instruc     in   32  instruction from fetch
//   if_id_nextpc      in   32  PC+4 of if_id_instruc
//   id_rf_addra/b     out  5   register-file read addresses (rs, rt), combinational
//   rf_id_dataa/b     in   32  register-file read data, same cycle
//   ex_regdest        in   5   destination register of instruction in EX
//   ex_writereg       in   1   EX instruction writes a register
//   ex_memread        in   1   EX instruction is a load
//   mem_regdest       in   5   destination register of instruction in MEM
//   mem_memread       in   1   MEM instruction is a load
//   id_stall          out  1   fetch hold, combinational
//   id_if_selpcsource out  1   redirect request, combinational
//   id_if_selpctype   out  2   00 branch, 01 register, 10 jump index, 11 exception
//   id_if_pcimd2ext   out  32  if_id_nextpc + (sext(imm16)<<2)
//   id_if_rega        out  32  rs value (JR/JALR target)
//   id_if_pcindex     out  32  {if_id_nextpc[31:28], instr[25:0], 2'b00}
//   id_ex_valid       out  1   ID/EX holds a real instruction
//   id_ex_instruc, id_ex_nextpc, id_ex_rega, id_ex_regb, id_ex_imedext  out 32 each  registered
//   id_ex_regdest     out  5   rd (R-type), rt (I-type), 31 (JAL/JALR)
//   id_ex_writereg/memread/memwrite/exc  out 1 each  registered controls; exc = exception taken
//   id_ex_epc         out  32  if_id_nextpc - 4 of the faulting instruction
// BEHAVIOUR
//   Reset: every id_ex_* output 0, FSM = RUN. Combinational outputs follow from NOP (32'h0).
//   Decode: BEQ 000100, BNE 000101, J 000010, JAL 000011, JR/JALR funct 001000/001001, SYSCALL funct 001100.
//     Any opcode outside the supported set is illegal.
//   Hazard stall (RUN only): register 0 never matches.
//     ex_memread and ex_regdest in {rs,rt}                               -> stall
//     branch/JR/JALR and ex_writereg and ex_regdest in its source regs   -> stall
//     branch/JR/JALR and mem_memread and mem_regdest in its source regs  -> stall
//   While id_stall=1:
//     selpcsource forced 0.
//     ID/EX loads a bubble: valid=0, writereg=memread=memwrite=exc=0.
//     Fetch holds if_id_instruc; ID re-evaluates next cycle.
//   Redirect (RUN, no stall) asserts selpcsource in the same cycle.
//     BEQ/BNE: when rf_id_dataa ==/!= rf_id_datab, type 00.
//     J/JAL: type 10.  JR/JALR: type 01.
//     Illegal or SYSCALL: type 11, id_ex_exc=1, id_ex_epc=nextpc-4, writereg/mem controls 0.
//   Delay slot: the instruction after a taken branch/jump executes normally.
//   JAL/JALR: id_ex_regb = if_id_nextpc + 4 (link value).
//   FSM: RUN -> SQUASH on an accepted exception redirect; SQUASH -> RUN after 1 cycle.
//     SQUASH: the incoming slot is treated as NOP -> bubble, no stall, no redirect, no exception.
//   Simultaneous events: stall beats redirect; an exception with a hazard waits until the stall clears.
//   Latency: 1 cycle ID -> ID/EX. id_if_* and id_stall are purely combinational from current inputs.
//   Arithmetic: target adds are 32-bit modulo (wrap silently). imedext is sign-extended; ANDI/ORI/XORI zero-extended.
//   Reset mid-operation: asynchronous clear to the reset state, including out of SQUASH.
// STRUCTURE
//   Shared include/package: opcode + funct constants, selpctype codes, EXC_VECTOR, NOP constant.
//   Sub-module hazard_unit: combinational stall from rs/rt/branch-class vs EX/MEM.
//   Top level holds: decoder, target adders, FSM, ID/EX register.
// TESTING
//   Reset low mid-run -> all id_ex_* 0, FSM RUN.
//   BEQ r1,r2,+3 at PC 0x10 with r1=r2=5 -> selpcsource=1, type 00, pcimd2ext=0x20; slot at 0x14 reaches EX valid.
//   LW r3 in EX, next ADD uses r3 -> id_stall=1 for 1 cycle, bubble in ID/EX, ADD issues next cycle.
//   BNE on r4 with ALU write of r4 in EX then load of r4 in MEM -> stall 2 cycles, then redirect.
//   Opcode 6'h3F at PC 0x8 -> type 11, id_ex_exc=1, epc=0x8; next cycle bubble (SQUASH); third cycle RUN.
//   J 0x0000040 at nextpc 0xF000_0004 -> type 10, pcindex=0xF000_0100; JAL sets regdest=31, regb=0xF000_0008.

Source files
------------

// File: rtl/decode_pc_control_pkg.sv
// Shared decode constants, selpctype codes and the ID/EX payload layout.
package decode_pc_control_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned RW   = 5;

   localparam logic [XLEN-1:0] EXC_VECTOR = 32'h0000_0040;
   localparam logic [XLEN-1:0] NOP        = 32'h0000_0000;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] OP_ADDI    = 6'h08;
   localparam logic [5:0] OP_ANDI    = 6'h0C;
   localparam logic [5:0] OP_ORI     = 6'h0D;
   localparam logic [5:0] OP_XORI    = 6'h0E;
   localparam logic [5:0] OP_LUI     = 6'h0F;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_SW      = 6'h2B;

   localparam logic [5:0] FN_JR      = 6'h08;
   localparam logic [5:0] FN_JALR    = 6'h09;
   localparam logic [5:0] FN_SYSCALL = 6'h0C;

   typedef enum logic [1:0] {
      PCT_BRANCH = 2'b00,
      PCT_REG    = 2'b01,
      PCT_JUMP   = 2'b10,
      PCT_EXC    = 2'b11
   } pctype_e;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_SQUASH = 1'b1
   } state_e;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] instruc;
      logic [XLEN-1:0] nextpc;
      logic [XLEN-1:0] rega;
      logic [XLEN-1:0] regb;
      logic [XLEN-1:0] imedext;
      logic [RW-1:0]   regdest;
      logic            writereg;
      logic            memread;
      logic            memwrite;
      logic            exc;
      logic [XLEN-1:0] epc;
   } id_ex_t;

endpackage

// File: rtl/decode_pc_control_hazard_unit.sv
// Load-use and branch-operand hazard detection against EX and MEM.
module decode_pc_control_hazard_unit
   import decode_pc_control_pkg::*;
(
   input  logic [RW-1:0] rs,
   input  logic [RW-1:0] rt,
   input  logic          branch_rs,
   input  logic          branch_rt,
   input  logic [RW-1:0] ex_regdest,
   input  logic          ex_writereg,
   input  logic          ex_memread,
   input  logic [RW-1:0] mem_regdest,
   input  logic          mem_memread,
   output logic          stall
);

   logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;

   // Register 0 is hard-wired, so it never creates a dependency.
   always_comb begin
      ex_hit_rs  = (ex_regdest  != '0) && (ex_regdest  == rs);
      ex_hit_rt  = (ex_regdest  != '0) && (ex_regdest  == rt);
      mem_hit_rs = (mem_regdest != '0) && (mem_regdest == rs);
      mem_hit_rt = (mem_regdest != '0) && (mem_regdest == rt);
      stall = (ex_memread  && (ex_hit_rs || ex_hit_rt))
           || (ex_writereg && ((branch_rs && ex_hit_rs)  || (branch_rt && ex_hit_rt)))
           || (mem_memread && ((branch_rs && mem_hit_rs) || (branch_rt && mem_hit_rt)));
   end

endmodule

// File: rtl/decode_pc_control.sv
// ID stage: decode, branch/jump/exception redirect, hazard stall and ID/EX register.
module decode_pc_control
   import decode_pc_control_pkg::*;
(
   input  logic            clock,
   input  logic            reset,
   input  logic [XLEN-1:0] if_id_instruc,
   input  logic [XLEN-1:0] if_id_nextpc,
   output logic [RW-1:0]   id_rf_addra,
   output logic [RW-1:0]   id_rf_addrb,
   input  logic [XLEN-1:0] rf_id_dataa,
   input  logic [XLEN-1:0] rf_id_datab,
   input  logic [RW-1:0]   ex_regdest,
   input  logic            ex_writereg,
   input  logic            ex_memread,
   input  logic [RW-1:0]   mem_regdest,
   input  logic            mem_memread,
   output logic            id_stall,
   output logic            id_if_selpcsource,
   output logic [1:0]      id_if_selpctype,
   output logic [XLEN-1:0] id_if_pcimd2ext,
   output logic [XLEN-1:0] id_if_rega,
   output logic [XLEN-1:0] id_if_pcindex,
   output logic            id_ex_valid,
   output logic [XLEN-1:0] id_ex_instruc,
   output logic [XLEN-1:0] id_ex_nextpc,
   output logic [XLEN-1:0] id_ex_rega,
   output logic [XLEN-1:0] id_ex_regb,
   output logic [XLEN-1:0] id_ex_imedext,
   output logic [RW-1:0]   id_ex_regdest,
   output logic            id_ex_writereg,
   output logic            id_ex_memread,
   output logic            id_ex_memwrite,
   output logic            id_ex_exc,
   output logic [XLEN-1:0] id_ex_epc
);

   state_e          state, state_next;
   id_ex_t          id_ex_q, id_ex_d;
   pctype_e         sel_type;
   logic [XLEN-1:0] instr, link, epc;
   logic [5:0]      opcode, funct;
   logic [RW-1:0]   rs, rt, rd;
   logic [15:0]     imm;
   logic            is_special, is_j, is_jal, is_beq, is_bne, is_jr, is_jalr, is_sys;
   logic            is_alui, is_lw, is_sw, is_exc, branch_rs, branch_rt, hz_stall;
   logic [XLEN-1:0] dec_imedext;
   logic [RW-1:0]   dec_regdest;
   logic            dec_writereg;

   // The slot behind an accepted exception is replaced by a NOP.
   assign instr  = (state == ST_SQUASH) ? NOP : if_id_instruc;
   assign opcode = instr[31:26];
   assign rs     = instr[25:21];
   assign rt     = instr[20:16];
   assign rd     = instr[15:11];
   assign imm    = instr[15:0];
   assign funct  = instr[5:0];

   assign id_rf_addra     = rs;
   assign id_rf_addrb     = rt;
   assign id_if_rega      = rf_id_dataa;
   assign id_if_pcimd2ext = if_id_nextpc + {{14{imm[15]}}, imm, 2'b00};
   assign id_if_pcindex   = {if_id_nextpc[31:28], instr[25:0], 2'b00};
   assign id_if_selpctype = sel_type;
   assign link            = if_id_nextpc + 32'd4;
   assign epc             = if_id_nextpc - 32'd4;

   // Instruction class decode and per-class controls.
   always_comb begin
      is_special = (opcode == OP_SPECIAL);
      is_j       = (opcode == OP_J);
      is_jal     = (opcode == OP_JAL);
      is_beq     = (opcode == OP_BEQ);
      is_bne     = (opcode == OP_BNE);
      is_jr      = is_special && (funct == FN_JR);
      is_jalr    = is_special && (funct == FN_JALR);
      is_sys     = is_special && (funct == FN_SYSCALL);
      is_alui    = (opcode >= OP_ADDI) && (opcode <= OP_LUI);
      is_lw      = (opcode == OP_LW);
      is_sw      = (opcode == OP_SW);
      is_exc     = is_sys || !(is_special || is_j || is_jal || is_beq || is_bne
                               || is_alui || is_lw || is_sw);
      branch_rs  = is_beq || is_bne || is_jr || is_jalr;
      branch_rt  = is_beq || is_bne;
      if ((opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI))
         dec_imedext = {16'h0000, imm};
      else
         dec_imedext = {{16{imm[15]}}, imm};
      if (is_jal || is_jalr)
         dec_regdest = 5'd31;
      else if (is_special)
         dec_regdest = rd;
      else
         dec_regdest = rt;
      dec_writereg = (is_special && !is_jr && !is_sys) || is_alui || is_lw || is_jal;
   end

   decode_pc_control_hazard_unit u_hazard (
      .rs          (rs),
      .rt          (rt),
      .branch_rs   (branch_rs),
      .branch_rt   (branch_rt),
      .ex_regdest  (ex_regdest),
      .ex_writereg (ex_writereg),
      .ex_memread  (ex_memread),
      .mem_regdest (mem_regdest),
      .mem_memread (mem_memread),
      .stall       (hz_stall)
   );

   // FSM next state, redirect selection and ID/EX next value; stall beats redirect.
   always_comb begin
      state_next        = state;
      id_stall          = 1'b0;
      id_if_selpcsource = 1'b0;
      sel_type          = PCT_BRANCH;
      id_ex_d           = '0;
      unique case (state)
         ST_RUN: begin
            id_stall = hz_stall;
            if (!hz_stall) begin
               id_ex_d.valid   = 1'b1;
               id_ex_d.instruc = instr;
               id_ex_d.nextpc  = if_id_nextpc;
               id_ex_d.rega    = rf_id_dataa;
               id_ex_d.regb    = (is_jal || is_jalr) ? link : rf_id_datab;
               id_ex_d.imedext = dec_imedext;
               id_ex_d.regdest = dec_regdest;
               if (is_exc) begin
                  id_if_selpcsource = 1'b1;
                  sel_type          = PCT_EXC;
                  id_ex_d.exc       = 1'b1;
                  id_ex_d.epc       = epc;
                  state_next        = ST_SQUASH;
               end else begin
                  id_ex_d.writereg = dec_writereg;
                  id_ex_d.memread  = is_lw;
                  id_ex_d.memwrite = is_sw;
                  if ((is_beq && (rf_id_dataa == rf_id_datab))
                      || (is_bne && (rf_id_dataa != rf_id_datab))) begin
                     id_if_selpcsource = 1'b1;
                     sel_type          = PCT_BRANCH;
                  end else if (is_j || is_jal) begin
                     id_if_selpcsource = 1'b1;
                     sel_type          = PCT_JUMP;
                  end else if (is_jr || is_jalr) begin
                     id_if_selpcsource = 1'b1;
                     sel_type          = PCT_REG;
                  end
               end
            end
         end
         ST_SQUASH: state_next = ST_RUN;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= ST_RUN;
      else        state <= state_next;
   end

   // ID/EX pipeline register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) id_ex_q <= '0;
      else        id_ex_q <= id_ex_d;
   end

   assign id_ex_valid    = id_ex_q.valid;
   assign id_ex_instruc  = id_ex_q.instruc;
   assign id_ex_nextpc   = id_ex_q.nextpc;
   assign id_ex_rega     = id_ex_q.rega;
   assign id_ex_regb     = id_ex_q.regb;
   assign id_ex_imedext  = id_ex_q.imedext;
   assign id_ex_regdest  = id_ex_q.regdest;
   assign id_ex_writereg = id_ex_q.writereg;
   assign id_ex_memread  = id_ex_q.memread;
   assign id_ex_memwrite = id_ex_q.memwrite;
   assign id_ex_exc      = id_ex_q.exc;
   assign id_ex_epc      = id_ex_q.epc;

endmodule

// File: tb/tb_decode_pc_control.sv
// Scoreboard bench for decode_pc_control.
module tb_decode_pc_control;

   logic        clock, reset;
   logic [31:0] if_id_instruc, if_id_nextpc, rf_id_dataa, rf_id_datab;
   logic [4:0]  id_rf_addra, id_rf_addrb, ex_regdest, mem_regdest, id_ex_regdest;
   logic        ex_writereg, ex_memread, mem_memread;
   logic        id_stall, id_if_selpcsource;
   logic [1:0]  id_if_selpctype;
   logic [31:0] id_if_pcimd2ext, id_if_rega, id_if_pcindex;
   logic        id_ex_valid, id_ex_writereg, id_ex_memread, id_ex_memwrite, id_ex_exc;
   logic [31:0] id_ex_instruc, id_ex_nextpc, id_ex_rega, id_ex_regb, id_ex_imedext, id_ex_epc;

   typedef struct packed {
      logic        valid, wr, mr, mw, exc, full;
      logic [4:0]  rd;
      logic [31:0] imed, regb, epc;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   decode_pc_control dut (
      .clock(clock), .reset(reset),
      .if_id_instruc(if_id_instruc), .if_id_nextpc(if_id_nextpc),
      .id_rf_addra(id_rf_addra), .id_rf_addrb(id_rf_addrb),
      .rf_id_dataa(rf_id_dataa), .rf_id_datab(rf_id_datab),
      .ex_regdest(ex_regdest), .ex_writereg(ex_writereg), .ex_memread(ex_memread),
      .mem_regdest(mem_regdest), .mem_memread(mem_memread),
      .id_stall(id_stall), .id_if_selpcsource(id_if_selpcsource),
      .id_if_selpctype(id_if_selpctype), .id_if_pcimd2ext(id_if_pcimd2ext),
      .id_if_rega(id_if_rega), .id_if_pcindex(id_if_pcindex),
      .id_ex_valid(id_ex_valid), .id_ex_instruc(id_ex_instruc), .id_ex_nextpc(id_ex_nextpc),
      .id_ex_rega(id_ex_rega), .id_ex_regb(id_ex_regb), .id_ex_imedext(id_ex_imedext),
      .id_ex_regdest(id_ex_regdest), .id_ex_writereg(id_ex_writereg),
      .id_ex_memread(id_ex_memread), .id_ex_memwrite(id_ex_memwrite),
      .id_ex_exc(id_ex_exc), .id_ex_epc(id_ex_epc)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] r_type(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'h00, fn};
   endfunction

   function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs, rt,
                                          input logic [15:0] im);
      return {op, rs, rt, im};
   endfunction

   function automatic logic [31:0] j_type(input logic [5:0] op, input logic [25:0] idx);
      return {op, idx};
   endfunction

   function automatic exp_t mk(input logic wr, mr, mw, input logic [4:0] rd,
                               input logic [31:0] imed, regb);
      exp_t e = '0;
      e.valid = 1'b1; e.full = 1'b1;
      e.wr = wr; e.mr = mr; e.mw = mw; e.rd = rd; e.imed = imed; e.regb = regb;
      return e;
   endfunction

   function automatic exp_t mkexc(input logic [31:0] epc);
      exp_t e = '0;
      e.valid = 1'b1; e.exc = 1'b1; e.epc = epc;
      return e;
   endfunction

   localparam exp_t BUB = '0;

   // Drive one ID slot, check the combinational redirect/stall, queue the ID/EX expectation.
   task automatic drive(input string tag, input logic [31:0] ins, npc, a, b,
                        input logic [4:0] exrd, input logic exw, exmr,
                        input logic [4:0] mrd, input logic mmr,
                        input logic xs, xsel, input logic [1:0] xtype, input exp_t e);
      if_id_instruc = ins; if_id_nextpc = npc; rf_id_dataa = a; rf_id_datab = b;
      ex_regdest = exrd; ex_writereg = exw; ex_memread = exmr;
      mem_regdest = mrd; mem_memread = mmr;
      #2;
      check({tag, " stall"}, 32'(id_stall), 32'(xs));
      check({tag, " selpcsource"}, 32'(id_if_selpcsource), 32'(xsel));
      if (xsel) check({tag, " selpctype"}, 32'(id_if_selpctype), 32'(xtype));
      sb.push_back(e);
   endtask

   // Clock the slot into ID/EX and compare against the oldest expectation.
   task automatic tick(input string tag);
      exp_t e;
      @(posedge clock);
      #1;
      if (sb.size() == 0) begin
         check({tag, " scoreboard empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check({tag, " valid"},    32'(id_ex_valid),    32'(e.valid));
         check({tag, " writereg"}, 32'(id_ex_writereg), 32'(e.wr));
         check({tag, " memread"},  32'(id_ex_memread),  32'(e.mr));
         check({tag, " memwrite"}, 32'(id_ex_memwrite), 32'(e.mw));
         check({tag, " exc"},      32'(id_ex_exc),      32'(e.exc));
         if (e.full) begin
            check({tag, " regdest"}, 32'(id_ex_regdest), 32'(e.rd));
            check({tag, " imedext"}, id_ex_imedext, e.imed);
            check({tag, " regb"},    id_ex_regb,    e.regb);
         end
         if (e.exc) check({tag, " epc"}, id_ex_epc, e.epc);
      end
   endtask

   logic [31:0] ins;

   initial begin
      reset = 1'b0;
      if_id_instruc = '0; if_id_nextpc = '0; rf_id_dataa = '0; rf_id_datab = '0;
      ex_regdest = '0; ex_writereg = 1'b0; ex_memread = 1'b0;
      mem_regdest = '0; mem_memread = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check("reset valid", 32'(id_ex_valid), 32'd0);
      check("reset exc", 32'(id_ex_exc), 32'd0);
      check("reset instruc", id_ex_instruc, 32'd0);
      check("reset epc", id_ex_epc, 32'd0);
      check("reset stall", 32'(id_stall), 32'd0);
      check("reset selpcsource", 32'(id_if_selpcsource), 32'd0);
      reset = 1'b1;

      // Taken BEQ and its delay slot
      drive("beq", i_type(6'h04, 5'd1, 5'd2, 16'd3), 32'h14, 32'd5, 32'd5,
            5'd0, 0, 0, 5'd0, 0, 0, 1, 2'b00, mk(0, 0, 0, 5'd2, 32'd3, 32'd5));
      check("beq pcimd2ext", id_if_pcimd2ext, 32'h20);
      check("beq addra", 32'(id_rf_addra), 32'd1);
      check("beq addrb", 32'(id_rf_addrb), 32'd2);
      tick("beq");
      drive("slot", r_type(5'd1, 5'd2, 5'd5, 6'h20), 32'h18, 32'd5, 32'd5,
            5'd0, 0, 0, 5'd0, 0, 0, 0, 2'b00, mk(1, 0, 0, 5'd5, 32'h2820, 32'd5));
      tick("slot");

      // Load-use: one bubble then issue
      drive("lu stall", r_type(5'd3, 5'd4, 5'd6, 6'h20), 32'h1C, 32'd1, 32'd2,
            5'd3, 1, 1, 5'd0, 0, 1, 0, 2'b00, BUB);
      tick("lu stall");
      drive("lu issue", r_type(5'd3, 5'd4, 5'd6, 6'h20), 32'h1C, 32'd1, 32'd2,
            5'd0, 0, 0, 5'd3, 0, 0, 0, 2'b00, mk(1, 0, 0, 5'd6, 32'h3020, 32'd2));
      tick("lu issue");

      // ALU result / MEM load on non-branch operands: no stall
      drive("nb ex", r_type(5'd4, 5'd0, 5'd9, 6'h20), 32'h20, 32'd0, 32'd0,
            5'd4, 1, 0, 5'd4, 1, 0, 0, 2'b00, mk(1, 0, 0, 5'd9, 32'h4820, 32'd0));
      tick("nb ex");

      // BNE operand hazards: EX write, then MEM load, then redirect (backward)
      ins = i_type(6'h05, 5'd4, 5'd0, 16'hFFFE);
      drive("bne ex", ins, 32'h104, 32'd7, 32'd0, 5'd4, 1, 0, 5'd0, 0, 1, 0, 2'b00, BUB);
      tick("bne ex");
      drive("bne mem", ins, 32'h104, 32'd7, 32'd0, 5'd0, 0, 0, 5'd4, 1, 1, 0, 2'b00, BUB);
      tick("bne mem");
      drive("bne go", ins, 32'h104, 32'd7, 32'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 2'b00,
            mk(0, 0, 0, 5'd0, 32'hFFFF_FFFE, 32'd0));
      check("bne pcimd2ext", id_if_pcimd2ext, 32'h0000_00FC);
      tick("bne go");

      // BEQ not taken, target add wraps
      drive("beq nt", i_type(6'h04, 5'd1, 5'd2, 16'd2), 32'hFFFF_FFFC, 32'd1, 32'd2,
            5'd0, 0, 0, 5'd0, 0, 0, 0, 2'b00, mk(0, 0, 0, 5'd2, 32'd2, 32'd2));
      check("beq wrap pcimd2ext", id_if_pcimd2ext, 32'h0000_0004);
      tick("beq nt");

      // Illegal opcode: exception, squash, back to RUN
      drive("ill", 32'hFC00_0000, 32'h0C, 32'd0, 32'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 2'b11,
            mkexc(32'h8));
      tick("ill");
      drive("squash", r_type(5'd1, 5'd2, 5'd7, 6'h20), 32'h10, 32'd3, 32'd4,
            5'd1, 1, 1, 5'd0, 0, 0, 0, 2'b00, BUB);
      check("squash addra", 32'(id_rf_addra), 32'd0);
      tick("squash");
      drive("run", r_type(5'd1, 5'd2, 5'd7, 6'h20), 32'h10, 32'd3, 32'd4,
            5'd0, 0, 0, 5'd0, 0, 0, 0, 2'b00, mk(1, 0, 0, 5'd7, 32'h3820, 32'd4));
      tick("run");

      // SYSCALL
      drive("sys", r_type(5'd0, 5'd0, 5'd0, 6'h0C), 32'h204, 32'd0, 32'd0,
            5'd0, 0, 0, 5'd0, 0, 0, 1, 2'b11, mkexc(32'h200));
      tick("sys");
      drive("sys squash", 32'd0, 32'h208, 32'd0, 32'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 2'b00, BUB);
      tick("sys squash");

      // Exception behind a load-use hazard waits for the stall
      ins = 32'hFC60_0000;
      drive("exh stall", ins, 32'h300, 32'd0, 32'd0, 5'd3, 1, 1, 5'd0, 0, 1, 0, 2'b00, BUB);
      tick("exh stall");
      drive("exh take", ins, 32'h300, 32'd0, 32'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 2'b11,
            mkexc(32'h2FC));
      tick("exh take");
      drive("exh squash", 32'd0, 32'h304, 32'd0, 32'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 2'b00, BUB);
      tick("exh squash");

      // J / JAL
      drive("j", j_type(6'h02, 26'h40), 32'hF000_0004, 32'd0, 32'd0,
            5'd0, 0, 0, 5'd0, 0, 0, 1, 2'b10, mk(0, 0, 0, 5'd0, 32'h40, 32'd0));
      check("j pcindex", id_if_pcindex, 32'hF000_0100);
      tick("j");
      drive("jal", j_type(6'h03, 26'h40), 32'hF000_0004, 32'd0, 32'd0,
            5'd0, 0, 0, 5'd0, 0, 0, 1, 2'b10, mk(1, 0, 0, 5'd31, 32'h40, 32'hF000_0008));
      tick("jal");

      // JR / JALR (JALR first stalls on a MEM load of its source)
      drive("jr", r_type(5'd9, 5'd0, 5'd0, 6'h08), 32'h400, 32'h1234, 32'd0,
            5'd0, 0, 0, 5'd0, 0, 0, 1, 2'b01, mk(0, 0, 0, 5'd0, 32'h8, 32'd0));
      check("jr rega", id_if_rega, 32'h1234);
      tick("jr");
      drive("jalr stall", r_type(5'd9, 5'd0, 5'd0, 6'h09), 32'h404, 32'h1234, 32'd0,
            5'd0, 0, 0, 5'd9, 1, 1, 0, 2'b00, BUB);
      tick("jalr stall");
      drive("jalr", r_type(5'd9, 5'd0, 5'd0, 6'h09), 32'h404, 32'h1234, 32'd0,
            5'd0, 0, 0, 5'd0, 0, 0, 1, 2'b01, mk(1, 0, 0, 5'd31, 32'h9, 32'h408));
      tick("jalr");

      // Immediate extension and memory controls
      drive("ori", i_type(6'h0D, 5'd1, 5'd8, 16'h8000), 32'h500, 32'd0, 32'd0,
            5'd0, 0, 0, 5'd0, 0, 0, 0, 2'b00, mk(1, 0, 0, 5'd8, 32'h0000_8000, 32'd0));
      tick("ori");
      drive("addi", i_type(6'h08, 5'd1, 5'd8, 16'h8000), 32'h504, 32'd0, 32'd0,
            5'd0, 0, 0, 5'd0, 0, 0, 0, 2'b00, mk(1, 0, 0, 5'd8, 32'hFFFF_8000, 32'd0));
      tick("addi");
      drive("lw", i_type(6'h23, 5'd1, 5'd10, 16'd4), 32'h508, 32'd0, 32'd0,
            5'd0, 0, 0, 5'd0, 0, 0, 0, 2'b00, mk(1, 1, 0, 5'd10, 32'd4, 32'd0));
      tick("lw");
      drive("sw", i_type(6'h2B, 5'd1, 5'd10, 16'd4), 32'h50C, 32'd0, 32'h55,
            5'd0, 0, 0, 5'd0, 0, 0, 0, 2'b00, mk(0, 0, 1, 5'd10, 32'd4, 32'h55));
      tick("sw");

      // Asynchronous reset out of SQUASH
      drive("rst ill", 32'hFC00_0000, 32'h604, 32'd0, 32'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 2'b11,
            mkexc(32'h600));
      tick("rst ill");
      #2 reset = 1'b0;
      #1;
      check("midrst valid", 32'(id_ex_valid), 32'd0);
      check("midrst exc", 32'(id_ex_exc), 32'd0);
      check("midrst epc", id_ex_epc, 32'd0);
      check("midrst instruc", id_ex_instruc, 32'd0);
      @(posedge clock);
      #1 reset = 1'b1;
      drive("post rst", r_type(5'd1, 5'd2, 5'd7, 6'h20), 32'h608, 32'd3, 32'd4,
            5'd0, 0, 0, 5'd0, 0, 0, 0, 2'b00, mk(1, 0, 0, 5'd7, 32'h3820, 32'd4));
      check("post rst addra", 32'(id_rf_addra), 32'd1);
      tick("post rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
